// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key sequencer: FSM states, scancode
// prefixes and the packed event layout {ext, brk, code}.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  localparam int EV_W = 10;

  // Bytes following E1 that make up the rest of the pause sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  function automatic logic [EV_W-1:0] make_ev(input logic ext, input logic brk,
                                              input logic [7:0] code);
    return {ext, brk, code};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO; head is shown while non-empty, the last popped entry
// is held on the output once it drains.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             push_ok, pop_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_MAX);

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign dout = empty ? last_q : mem_q[rd_q];

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PTR_ONE;
    end
    if (pop_ok) begin
      last_d = mem_q[rd_q];
      rd_d   = rd_q + PTR_ONE;
    end
    if (push_ok && !pop_ok)      cnt_d = cnt_q + CNT_ONE;
    else if (!push_ok && pop_ok) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Turns received PS/2 bytes into make/break key events queued in a FIFO.
// Define PS2_WATCHDOG_EN to add the stalled-receiver watchdog.
//
// state      | meaning
// IDLE       | waiting for first byte of a sequence
// EXT        | E0 seen
// BRK        | F0 seen
// EXT_BRK    | E0 F0 seen
// PAUSE      | E1 seen, swallowing the rest of the pause sequence
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int ERR_CNT_W      = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 rx_error,
  input  logic                 rx_busy,
  output logic                 rx_restart,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [7:0]           ev_code,
  output logic                 ev_ext,
  output logic                 ev_break,
  output logic                 ovf,
  input  logic                 ovf_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_e              state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic                push_q, push_d;
  logic [EV_W-1:0]     push_data_q, push_data_d;
  logic                ovf_q, ovf_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                timeout;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [EV_W-1:0]     fifo_dout;

`ifdef PS2_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = 1;

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_active;

  assign wd_active  = rx_busy || (state_q != ST_IDLE);
  // A byte arriving on the expiry cycle is progress, so it suppresses the timeout
  assign timeout    = wd_active && (wd_q == '0) && !rx_valid && !rx_error;
  assign rx_restart = timeout;

  always_comb begin
    wd_d = wd_q - WD_ONE;
    if (!wd_active || rx_valid || rx_error || timeout) wd_d = WD_LOAD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wd_q <= WD_LOAD;
    else        wd_q <= wd_d;
  end
`else
  logic unused_wd;
  assign unused_wd  = rx_busy ^ (TIMEOUT_CYCLES == 0);
  assign timeout    = 1'b0;
  assign rx_restart = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (rx_error) begin
      state_d = ST_IDLE;
      skip_d  = '0;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_EXT)        state_d = ST_EXT;
          else if (rx_data == SC_BRK)   state_d = ST_BRK;
          else if (rx_data == SC_PAUSE) begin
            state_d = ST_PAUSE;
            skip_d  = '0;
          end else begin
            push_d      = 1'b1;
            push_data_d = make_ev(1'b0, 1'b0, rx_data);
          end
        end
        ST_EXT: begin
          if (rx_data == SC_BRK) state_d = ST_EXT_BRK;
          else begin
            push_d      = 1'b1;
            push_data_d = make_ev(1'b1, 1'b0, rx_data);
            state_d     = ST_IDLE;
          end
        end
        ST_BRK: begin
          push_d      = 1'b1;
          push_data_d = make_ev(1'b0, 1'b1, rx_data);
          state_d     = ST_IDLE;
        end
        ST_EXT_BRK: begin
          push_d      = 1'b1;
          push_data_d = make_ev(1'b1, 1'b1, rx_data);
          state_d     = ST_IDLE;
        end
        ST_PAUSE: begin
          if (skip_q == PAUSE_SKIP - 3'd1) begin
            push_d      = 1'b1;
            push_data_d = make_ev(1'b1, 1'b0, SC_PAUSE);
            state_d     = ST_IDLE;
            skip_d      = '0;
          end else begin
            skip_d = skip_q + 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
      skip_d  = '0;
    end
  end

  assign fifo_pop = ev_valid && ev_ready;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (push_q && fifo_full && !fifo_pop) ovf_d = 1'b1;
    err_cnt_d = err_cnt_q;
    if ((rx_error || timeout) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      ovf_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      ovf_q       <= ovf_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EV_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_q),
    .din  (push_data_q),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_ext   = fifo_dout[9];
  assign ev_break = fifo_dout[8];
  assign ev_code  = fifo_dout[7:0];
  assign ovf      = ovf_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer; events are logged as {ext,brk,code}.
// The watchdog scenario runs only when PS2_WATCHDOG_EN is defined.
module tb_ps2_key_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid, rx_error, rx_busy, rx_restart;
  logic [7:0] rx_data;
  logic       ev_valid, ev_ready, ev_ext, ev_break, ovf, ovf_clr;
  logic [7:0] ev_code;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  logic [9:0] got[$];

  always #5 clk = ~clk;

  ps2_key_sequencer #(
    .FIFO_DEPTH(8),
    .ERR_CNT_W(8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_error  (rx_error),
    .rx_busy   (rx_busy),
    .rx_restart(rx_restart),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ev_ext    (ev_ext),
    .ev_break  (ev_break),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .err_cnt   (err_cnt)
  );

  // Inputs change 1ns after posedge, so at negedge both sides are stable
  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) got.push_back({ev_ext, ev_break, ev_code});
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    rx_error = err;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic send_error();
    @(posedge clk); #1;
    rx_error = 1'b1;
    @(posedge clk); #1;
    rx_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b0 || ev_code !== 8'h00 || ev_ext !== 1'b0 || ev_break !== 1'b0) begin
      errors++;
      $display("FAIL reset_ev: got valid=%b ext=%b brk=%b code=%h, want 0 0 0 00",
               ev_valid, ev_ext, ev_break, ev_code);
    end
    checks++;
    if (ovf !== 1'b0 || err_cnt !== 8'd0 || rx_restart !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got ovf=%b err_cnt=%0d restart=%b, want 0 0 0",
               ovf, err_cnt, rx_restart);
    end
  endtask

  task automatic test_latency();
    got.delete();
    ev_ready = 1'b0;
    send_byte(8'h2A, 1'b0);
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: ev_valid got %b, want 0 one cycle after byte", ev_valid);
    end
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b1 || {ev_ext, ev_break, ev_code} !== 10'h02A) begin
      errors++;
      $display("FAIL latency_head: got valid=%b ev=%h, want 1 02A",
               ev_valid, {ev_ext, ev_break, ev_code});
    end
    @(posedge clk); #1;
    ev_ready = 1'b1;
    idle(3);
    checks++;
    if (got.size() != 1 || got[0] !== 10'h02A) begin
      errors++;
      $display("FAIL latency_pop: got %0d events first=%h, want 1 event 02A",
               got.size(), (got.size() > 0) ? got[0] : 10'h3FF);
    end
  endtask

  task automatic test_make_break();
    got.delete();
    send_byte(8'h1C, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    idle(4);
    checks++;
    if (got.size() != 2 || got[0] !== 10'h01C || got[1] !== 10'h11C) begin
      errors++;
      $display("FAIL make_break: got %0d events %h %h, want 2 events 01C 11C", got.size(),
               (got.size() > 0) ? got[0] : 10'h3FF, (got.size() > 1) ? got[1] : 10'h3FF);
    end
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b0 || {ev_ext, ev_break, ev_code} !== 10'h11C) begin
      errors++;
      $display("FAIL empty_hold: got valid=%b ev=%h, want 0 11C",
               ev_valid, {ev_ext, ev_break, ev_code});
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq [5];
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    got.delete();
    for (int i = 0; i < 5; i++) send_byte(seq[i], 1'b0);
    idle(4);
    checks++;
    if (got.size() != 2 || got[0] !== 10'h275 || got[1] !== 10'h375) begin
      errors++;
      $display("FAIL extended: got %0d events %h %h, want 2 events 275 375", got.size(),
               (got.size() > 0) ? got[0] : 10'h3FF, (got.size() > 1) ? got[1] : 10'h3FF);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    got.delete();
    for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b0);
    idle(4);
    checks++;
    if (got.size() != 1 || got[0] !== 10'h2E1) begin
      errors++;
      $display("FAIL pause: got %0d events first=%h, want 1 event 2E1",
               got.size(), (got.size() > 0) ? got[0] : 10'h3FF);
    end
  endtask

  task automatic test_error();
    got.delete();
    send_byte(8'hE0, 1'b0);
    send_error();
    send_byte(8'h1C, 1'b0);
    idle(4);
    checks++;
    if (err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL error_count: got %0d, want 1", err_cnt);
    end
    checks++;
    if (got.size() != 1 || got[0] !== 10'h01C) begin
      errors++;
      $display("FAIL error_abort: got %0d events first=%h, want 1 event 01C",
               got.size(), (got.size() > 0) ? got[0] : 10'h3FF);
    end
    got.delete();
    send_byte(8'h33, 1'b1);
    idle(4);
    checks++;
    if (err_cnt !== 8'd2 || got.size() != 0) begin
      errors++;
      $display("FAIL error_wins: got err_cnt=%0d events=%0d, want 2 and 0",
               err_cnt, got.size());
    end
  endtask

  task automatic test_overflow();
    got.delete();
    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 1'b0);
    idle(3);
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b1 || ovf !== 1'b1 || {ev_ext, ev_break, ev_code} !== 10'h010) begin
      errors++;
      $display("FAIL ovf_full: got valid=%b ovf=%b head=%h, want 1 1 010",
               ev_valid, ovf, {ev_ext, ev_break, ev_code});
    end
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got ovf=%b, want 0", ovf);
    end
    ev_ready = 1'b1;
    idle(12);
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL drain_count: got %0d events, want 8", got.size());
    end
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        checks++;
        if (got[i] !== {2'b00, 8'h10 + 8'(i)}) begin
          errors++;
          $display("FAIL drain_order[%0d]: got %h, want %h", i, got[i], {2'b00, 8'h10 + 8'(i)});
        end
      end
    end
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got valid=%b ovf=%b, want 0 0", ev_valid, ovf);
    end
  endtask

`ifdef PS2_WATCHDOG_EN
  task automatic test_watchdog();
    int hit;
    hit = -1;
    apply_reset();
    got.delete();
    send_byte(8'hF0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rx_restart === 1'b1) begin
        hit = i;
        break;
      end
    end
    checks++;
    if (hit != 99) begin
      errors++;
      $display("FAIL wd_restart_cycle: got %0d, want 99 (-1 = no pulse)", hit);
    end
    @(negedge clk);
    checks++;
    if (rx_restart !== 1'b0 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL wd_after: got restart=%b err_cnt=%0d, want 0 1", rx_restart, err_cnt);
    end
    send_byte(8'h1C, 1'b0);
    idle(4);
    checks++;
    if (got.size() != 1 || got[0] !== 10'h01C) begin
      errors++;
      $display("FAIL wd_idle: got %0d events first=%h, want 1 event 01C",
               got.size(), (got.size() > 0) ? got[0] : 10'h3FF);
    end
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_error = 1'b0;
    rx_busy  = 1'b0;
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
    apply_reset();
    test_reset();
    test_latency();
    test_make_break();
    test_extended();
    test_pause();
    test_error();
    test_overflow();
`ifdef PS2_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
